mdu_seq16: RTL and testbench

Sequential 16-bit unsigned multiply/divide unit for the MIPS 16-bit processor. It sits beside the ALU, downstream of the 16-bit adder/subtractor. It iterates one bit per clock through its own add/sub datapath and writes HI/LO result registers. It uses a start/busy/done handshake so the control unit can stall on MULT/DIV instructions.

---
 rtl/mdu_pkg.sv | 17 +
 rtl/mdu_seq16_if.sv | 24 ++
 rtl/mdu_addsub17.sv | 16 +
 rtl/mdu_seq16.sv | 153 +++++++++++++++
 tb/tb_mdu_seq16.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared constants, op encodings and FSM state type for the sequential
// 16-bit multiply/divide unit.
package mdu_pkg;

  localparam int MDU_W    = 16;
  localparam int MDU_ITER = 16;

  localparam logic OP_MULTU = 1'b0;
  localparam logic OP_DIVU  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mdu_seq16_if.sv
// Request/result bundle between the control unit (master) and the MDU (slave).
interface mdu_seq16_if;

  logic        start;
  logic        op;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] hi;
  logic [15:0] lo;
  logic        div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo, div_by_zero
  );

endinterface

// File: rtl/mdu_addsub17.sv
// Combinational 17-bit add/subtract shared by the multiply and divide steps.
// For subtraction cout is the inverted borrow (1 = no borrow).
module mdu_addsub17 (
  input  logic [16:0] x,
  input  logic [16:0] y,
  input  logic        sub,
  output logic [16:0] result,
  output logic        cout
);

  logic [16:0] y_eff;

  assign y_eff = sub ? ~y : y;
  assign {cout, result} = {1'b0, x} + {1'b0, y_eff} + {17'd0, sub};

endmodule

// File: rtl/mdu_seq16.sv
// Sequential 16-bit unsigned MULTU/DIVU, one bit per clock, HI/LO results.
// Define MDU_DIVIDE_EN to build the restoring divider; otherwise DIVU returns zeros.
module mdu_seq16
  import mdu_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  mdu_seq16_if.slave    bus
);

  state_t      state_reg;
  logic [3:0]  count_reg;
  logic [15:0] opnd_reg;      // multiplicand for MULTU, divisor for DIVU
  logic [15:0] work_hi_reg;   // acc / partial remainder
  logic [15:0] work_lo_reg;   // mq / quotient
  logic [15:0] hi_reg;
  logic [15:0] lo_reg;
  logic        busy_reg;
  logic        done_reg;
  logic        dbz_reg;
`ifdef MDU_DIVIDE_EN
  logic        op_reg;
  logic [16:0] shifted;
`endif

  logic [16:0] as_x;
  logic [16:0] as_y;
  logic        as_sub;
  logic [16:0] as_res;
  logic        as_cout;

  logic [15:0] acc_new;
  logic        c_new;
  logic [15:0] work_hi_next;
  logic [15:0] work_lo_next;

  mdu_addsub17 u_addsub (
    .x      (as_x),
    .y      (as_y),
    .sub    (as_sub),
    .result (as_res),
    .cout   (as_cout)
  );

  always_comb begin
    as_x   = {1'b0, work_hi_reg};
    as_y   = {1'b0, opnd_reg};
    as_sub = 1'b0;
`ifdef MDU_DIVIDE_EN
    shifted = {work_hi_reg, work_lo_reg[15]};
    if (op_reg == OP_DIVU) begin
      as_x   = shifted;
      as_sub = 1'b1;
    end
`endif
  end

  always_comb begin
    // Operands are zero-extended, so the sum never reaches cout; folding it in is harmless.
    acc_new      = work_lo_reg[0] ? as_res[15:0] : work_hi_reg;
    c_new        = work_lo_reg[0] & (as_res[16] | as_cout);
    work_hi_next = {c_new, acc_new[15:1]};
    work_lo_next = {acc_new[0], work_lo_reg[15:1]};
`ifdef MDU_DIVIDE_EN
    if (op_reg == OP_DIVU) begin
      work_hi_next = as_cout ? as_res[15:0] : shifted[15:0];
      work_lo_next = {work_lo_reg[14:0], as_cout};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      count_reg   <= 4'd0;
      opnd_reg    <= 16'd0;
      work_hi_reg <= 16'd0;
      work_lo_reg <= 16'd0;
      hi_reg      <= 16'd0;
      lo_reg      <= 16'd0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      dbz_reg     <= 1'b0;
`ifdef MDU_DIVIDE_EN
      op_reg      <= OP_MULTU;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (bus.start) begin
            count_reg   <= 4'd0;
            dbz_reg     <= 1'b0;
            work_hi_reg <= 16'd0;
            work_lo_reg <= (bus.op == OP_DIVU) ? bus.a : bus.b;
            opnd_reg    <= (bus.op == OP_DIVU) ? bus.b : bus.a;
`ifdef MDU_DIVIDE_EN
            op_reg      <= bus.op;
            if (bus.op == OP_DIVU && bus.b == 16'd0) begin
              hi_reg    <= bus.a;
              lo_reg    <= 16'hFFFF;
              dbz_reg   <= 1'b1;
              done_reg  <= 1'b1;
              busy_reg  <= 1'b0;
              state_reg <= DONE;
            end else begin
              busy_reg  <= 1'b1;
              state_reg <= RUN;
            end
`else
            if (bus.op == OP_DIVU) begin
              hi_reg    <= 16'd0;
              lo_reg    <= 16'd0;
              done_reg  <= 1'b1;
              busy_reg  <= 1'b0;
              state_reg <= DONE;
            end else begin
              busy_reg  <= 1'b1;
              state_reg <= RUN;
            end
`endif
          end else begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        RUN: begin
          work_hi_reg <= work_hi_next;
          work_lo_reg <= work_lo_next;
          count_reg   <= count_reg + 4'd1;
          if (count_reg == 4'(MDU_ITER - 1)) begin
            hi_reg    <= work_hi_next;
            lo_reg    <= work_lo_next;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= DONE;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.hi          = hi_reg;
  assign bus.lo          = lo_reg;
  assign bus.div_by_zero = dbz_reg;

endmodule

// File: tb/tb_mdu_seq16.sv
// Directed self-checking bench for mdu_seq16 (expectations follow MDU_DIVIDE_EN).
`timescale 1ns/1ps
module tb_mdu_seq16;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  mdu_seq16_if bus ();

  mdu_seq16 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one request and measures it; callers do the comparisons.
  task automatic run_op(input logic op, input logic [15:0] a, input logic [15:0] b,
                        output int done_at, output int busy_cnt,
                        output logic [15:0] hi, output logic [15:0] lo,
                        output logic dbz, output logic done_acc, output logic dbz_acc);
    bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    done_acc = bus.done;
    dbz_acc  = bus.div_by_zero;
    done_at  = -1;
    busy_cnt = 0;
    for (int j = 0; j < 40; j++) begin
      if (bus.done === 1'b1) begin
        done_at = j + 1;
        break;
      end
      if (bus.busy === 1'b1) busy_cnt++;
      @(posedge clk); #1;
    end
    hi  = bus.hi;
    lo  = bus.lo;
    dbz = bus.div_by_zero;
    $display("op=%0d a=%h b=%h -> done_at=%0d busy=%0d hi=%h lo=%h dbz=%0d",
             op, a, b, done_at, busy_cnt, hi, lo, dbz);
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0; bus.op = 1'b0; bus.a = 16'd0; bus.b = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    total++; if (bus.hi !== 16'h0) begin bad++; $display("FAIL reset_hi got=%h exp=0000", bus.hi); end
    total++; if (bus.lo !== 16'h0) begin bad++; $display("FAIL reset_lo got=%h exp=0000", bus.lo); end
    total++; if (bus.div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b exp=0", bus.div_by_zero); end
    rst = 1'b0;
    @(posedge clk); #1;
    $display("reset checked");
  endtask

  task automatic test_multu();
    logic [15:0] va [3]; logic [15:0] vb [3]; logic [15:0] eh [3]; logic [15:0] el [3];
    int d; int bc; logic [15:0] h; logic [15:0] l; logic z; logic da; logic za;
    va[0] = 16'h1234; vb[0] = 16'h5678; eh[0] = 16'h0626; el[0] = 16'h0060;
    va[1] = 16'hFFFF; vb[1] = 16'hFFFF; eh[1] = 16'hFFFE; el[1] = 16'h0001;
    va[2] = 16'h0000; vb[2] = 16'hABCD; eh[2] = 16'h0000; el[2] = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      run_op(1'b0, va[i], vb[i], d, bc, h, l, z, da, za);
      total++; if (d !== 17) begin bad++; $display("FAIL multu_latency[%0d] got=%0d exp=17", i, d); end
      total++; if (bc !== 16) begin bad++; $display("FAIL multu_busy[%0d] got=%0d exp=16", i, bc); end
      total++; if (h !== eh[i]) begin bad++; $display("FAIL multu_hi[%0d] got=%h exp=%h", i, h, eh[i]); end
      total++; if (l !== el[i]) begin bad++; $display("FAIL multu_lo[%0d] got=%h exp=%h", i, l, el[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_divu();
    logic [15:0] va [2]; logic [15:0] vb [2]; logic [15:0] eh [2]; logic [15:0] el [2];
    int d; int bc; int ed; logic [15:0] h; logic [15:0] l; logic z; logic da; logic za;
`ifdef MDU_DIVIDE_EN
    ed = 17;
    va[0] = 16'd1000; vb[0] = 16'd7; eh[0] = 16'h0006; el[0] = 16'h008E;
    va[1] = 16'hFFFF; vb[1] = 16'd1; eh[1] = 16'h0000; el[1] = 16'hFFFF;
`else
    ed = 1;
    va[0] = 16'd1000; vb[0] = 16'd7; eh[0] = 16'h0000; el[0] = 16'h0000;
    va[1] = 16'hFFFF; vb[1] = 16'd1; eh[1] = 16'h0000; el[1] = 16'h0000;
`endif
    for (int i = 0; i < 2; i++) begin
      run_op(1'b1, va[i], vb[i], d, bc, h, l, z, da, za);
      total++; if (d !== ed) begin bad++; $display("FAIL divu_latency[%0d] got=%0d exp=%0d", i, d, ed); end
      total++; if (h !== eh[i]) begin bad++; $display("FAIL divu_hi[%0d] got=%h exp=%h", i, h, eh[i]); end
      total++; if (l !== el[i]) begin bad++; $display("FAIL divu_lo[%0d] got=%h exp=%h", i, l, el[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_div_by_zero();
    int d; int bc; logic [15:0] h; logic [15:0] l; logic z; logic da; logic za;
    logic [15:0] eh; logic [15:0] el; logic ez;
`ifdef MDU_DIVIDE_EN
    eh = 16'h1234; el = 16'hFFFF; ez = 1'b1;
`else
    eh = 16'h0000; el = 16'h0000; ez = 1'b0;
`endif
    run_op(1'b1, 16'h1234, 16'h0000, d, bc, h, l, z, da, za);
    total++; if (d !== 1) begin bad++; $display("FAIL dbz_latency got=%0d exp=1", d); end
    total++; if (h !== eh) begin bad++; $display("FAIL dbz_hi got=%h exp=%h", h, eh); end
    total++; if (l !== el) begin bad++; $display("FAIL dbz_lo got=%h exp=%h", l, el); end
    total++; if (z !== ez) begin bad++; $display("FAIL dbz_flag got=%b exp=%b", z, ez); end
    @(posedge clk); #1;
    total++; if (bus.div_by_zero !== ez) begin bad++; $display("FAIL dbz_hold got=%b exp=%b", bus.div_by_zero, ez); end
    run_op(1'b0, 16'd3, 16'd5, d, bc, h, l, z, da, za);
    total++; if (za !== 1'b0) begin bad++; $display("FAIL dbz_clear_on_accept got=%b exp=0", za); end
    total++; if (l !== 16'd15 || h !== 16'd0) begin bad++; $display("FAIL dbz_next_mult got=%h_%h exp=0000_000f", h, l); end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start();
    int done_at;
    bus.op = 1'b0; bus.a = 16'h1234; bus.b = 16'h5678; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    done_at = -1;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) begin
        bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.start = 1'b1;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        done_at = k + 1;
        break;
      end
    end
    $display("ignore_start: done_at=%0d hi=%h lo=%h", done_at, bus.hi, bus.lo);
    total++; if (done_at !== 17) begin bad++; $display("FAIL ignore_latency got=%0d exp=17", done_at); end
    total++; if (bus.hi !== 16'h0626) begin bad++; $display("FAIL ignore_hi got=%h exp=0626", bus.hi); end
    total++; if (bus.lo !== 16'h0060) begin bad++; $display("FAIL ignore_lo got=%h exp=0060", bus.lo); end
    @(posedge clk); #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ignore_no_requeue got=%b exp=0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    int d; int bc; logic [15:0] h; logic [15:0] l; logic z; logic da; logic za;
    run_op(1'b0, 16'd300, 16'd400, d, bc, h, l, z, da, za);
    total++; if (d !== 17 || h !== 16'h0001 || l !== 16'hD4C0) begin
      bad++; $display("FAIL b2b_first got=%0d/%h_%h exp=17/0001_d4c0", d, h, l);
    end
    run_op(1'b0, 16'h00FF, 16'h0101, d, bc, h, l, z, da, za);
    total++; if (da !== 1'b0) begin bad++; $display("FAIL b2b_done_falls got=%b exp=0", da); end
    total++; if (d !== 17) begin bad++; $display("FAIL b2b_latency got=%0d exp=17", d); end
    total++; if (bc !== 16) begin bad++; $display("FAIL b2b_busy got=%0d exp=16", bc); end
    total++; if (h !== 16'h0000 || l !== 16'hFFFF) begin bad++; $display("FAIL b2b_second got=%h_%h exp=0000_ffff", h, l); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    logic seen_done;
    bus.op = 1'b0; bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    $display("reset_abort: busy=%b done=%b hi=%h lo=%h", bus.busy, bus.done, bus.hi, bus.lo);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b exp=0", bus.done); end
    total++; if (bus.hi !== 16'h0) begin bad++; $display("FAIL abort_hi got=%h exp=0000", bus.hi); end
    total++; if (bus.lo !== 16'h0) begin bad++; $display("FAIL abort_lo got=%h exp=0000", bus.lo); end
    seen_done = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done = 1'b1;
    end
    total++; if (seen_done !== 1'b0) begin bad++; $display("FAIL abort_no_done got=%b exp=0", seen_done); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_multu();
    test_divu();
    test_div_by_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
